// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state codes,
// handshake levels and the EX-stage aluop codes that select DIV / DIVU.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    // state    | meaning
    // DIV_FREE | idle, waiting for start_i
    // DIV_BY_Z | divisor was zero, result is forced to 0 on the next edge
    // DIV_ON   | iterating, one quotient bit per clock
    // DIV_END  | result valid, held while start_i stays high
    typedef enum logic [1:0] {
        DIV_FREE = 2'b00,
        DIV_BY_Z = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left by one,
// trial-subtract the divisor from the widened remainder and keep the
// difference only when it did not go negative.
module div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // rem < dvs always holds, so the shifted value is < 2*dvs and the
    // borrow bit of the W+1 bit difference is a clean "less than" flag.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_dvs};
    assign w_ge    = ~w_diff[WIDTH];

    assign o_rem = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned integer divider for the EX stage.
// result_o = {remainder, quotient}, valid while ready_o is high.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int             CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e         r_state;
    div_state_e         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_neg_quo;
    logic               r_neg_rem;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic               w_start_ok;
    logic               w_last;
    logic [WIDTH-1:0]   w_op1_mag;
    logic [WIDTH-1:0]   w_op2_mag;
    logic [WIDTH-1:0]   w_step_rem;
    logic [WIDTH-1:0]   w_step_quo;
    logic [WIDTH-1:0]   w_fix_rem;
    logic [WIDTH-1:0]   w_fix_quo;
    logic [2*WIDTH-1:0] w_result_next;
    logic               w_ready_next;

    assign w_start_ok = start_i & ~annul_i;
    assign w_last     = (r_cnt == CNT_LAST);

    // Magnitudes are only taken in signed mode; unsigned operands pass as-is.
    assign w_op1_mag = (signed_div_i & opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    assign w_op2_mag = (signed_div_i & opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

    div_unit_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    // INT_MIN / -1 wraps naturally: magnitude 2^(W-1) negated is itself.
    assign w_fix_quo = r_neg_quo ? (~w_step_quo + WIDTH'(1)) : w_step_quo;
    assign w_fix_rem = r_neg_rem ? (~w_step_rem + WIDTH'(1)) : w_step_rem;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DIV_FREE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; annul_i returns any busy state to idle
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            DIV_FREE: begin
                if (w_start_ok) begin
                    w_next_state = (opdata2_i == '0) ? DIV_BY_Z : DIV_ON;
                end
            end
            DIV_BY_Z: begin
                w_next_state = annul_i ? DIV_FREE : DIV_END;
            end
            DIV_ON: begin
                if (annul_i) begin
                    w_next_state = DIV_FREE;
                end else if (w_last) begin
                    w_next_state = DIV_END;
                end
            end
            DIV_END: begin
                if (annul_i || !start_i) begin
                    w_next_state = DIV_FREE;
                end
            end
            default: w_next_state = DIV_FREE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_ready_next  = DIV_RESULT_NOT_READY;
        w_result_next = '0;
        unique case (r_state)
            DIV_FREE: begin
                w_ready_next  = DIV_RESULT_NOT_READY;
                w_result_next = '0;
            end
            DIV_BY_Z: begin
                if (!annul_i) begin
                    w_ready_next = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (!annul_i && w_last) begin
                    w_ready_next  = DIV_RESULT_READY;
                    w_result_next = {w_fix_rem, w_fix_quo};
                end
            end
            DIV_END: begin
                if (!annul_i && start_i) begin
                    w_ready_next  = r_ready;
                    w_result_next = r_result;
                end
            end
            default: begin
                w_ready_next  = DIV_RESULT_NOT_READY;
                w_result_next = '0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready  <= DIV_RESULT_NOT_READY;
            r_result <= '0;
        end else begin
            r_ready  <= w_ready_next;
            r_result <= w_result_next;
        end
    end

    // Working registers: operands captured on the start edge, then one step per clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_neg_quo <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (r_state == DIV_FREE) begin
            if (w_start_ok) begin
                r_cnt     <= '0;
                r_rem     <= '0;
                r_quo     <= w_op1_mag;
                r_dvs     <= w_op2_mag;
                r_neg_quo <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                r_neg_rem <= signed_div_i & opdata1_i[WIDTH-1];
            end
        end else if (r_state == DIV_ON) begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a vector table plus random unsigned
// divides, scoreboarded results, and hand-built annul/reset sequences.
module tb_div_unit;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          signed_div_i;
    logic [W-1:0]  opdata1_i;
    logic [W-1:0]  opdata2_i;
    logic          start_i;
    logic          annul_i;
    logic [2*W-1:0] result_o;
    logic          ready_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W-1:0] sb_q[$];

    typedef struct {
        logic          sg;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [2*W-1:0] exp;
        int            lat;
        int            hold;
    } vec_t;

    vec_t vecs[12];

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Issue one divide, wait for ready, compare against the scoreboard,
    // hold start for 'hold' cycles in END, then release and check the drop.
    task automatic do_div(input string name, input logic sg, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp,
                          input int lat, input int hold);
        int got;
        logic [2*W-1:0] e;
        @(negedge clk);
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk);
        got = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                got = k;
                break;
            end
            if (k == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~sg;
            end
        end
        check({name, " latency"}, 64'(got), 64'(lat));
        e = sb_q.pop_front();
        if (got != 0) begin
            check({name, " result"}, result_o, e);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                check({name, " hold"}, {result_o[2*W-1:1], ready_o}, {e[2*W-1:1], 1'b1});
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, " drop"}, {result_o, ready_o}, 65'd0);
    endtask

    initial begin
        int highs;
        logic [W-1:0] ra, rb;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 32, 1};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    32, 1};
        vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0, 32'h80000000},           32, 1};
        vecs[3]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'h0, 32'hFFFFFFFF},           32, 5};
        vecs[4]  = '{1'b0, 32'd5,          32'd0,          64'd0,                            1, 1};
        vecs[5]  = '{1'b1, 32'hFFFFFFF9,   32'd0,          64'd0,                            1, 1};
        vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},           32, 1};
        vecs[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF, 32'd3},           32, 1};
        vecs[8]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          {32'd1, 32'h7FFFFFFC},           32, 1};
        vecs[9]  = '{1'b0, 32'd9,          32'd3,          {32'd0, 32'd3},                  32, 1};
        vecs[10] = '{1'b0, 32'd3,          32'd9,          {32'd3, 32'd0},                  32, 1};
        vecs[11] = '{1'b1, 32'd0,          32'd5,          64'd0,                           32, 1};

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("reset", {result_o, ready_o}, 65'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_div($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat, vecs[i].hold);
        end

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i < 4) ? W'($urandom_range(1, 1000)) : $urandom;
            if (rb == 0) rb = 1;
            do_div($sformatf("rnd%0d", i), 1'b0, ra, rb, {ra % rb, ra / rb}, 32, 1);
        end

        // annul mid-divide: ready must never rise
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        highs = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) highs++;
        end
        check("annul_on", 64'(highs), 64'd0);
        do_div("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 32, 1);

        // annul in idle beats start
        @(negedge clk);
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        highs = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) highs++;
        end
        check("annul_idle", 64'(highs), 64'd0);

        // async reset mid-ON
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (6) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_on", {result_o, ready_o}, 65'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b1;
        do_div("after_rst_on", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 32, 1);

        // async reset while result is held: must clear before any edge
        @(negedge clk);
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        highs = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                highs = 1;
                break;
            end
        end
        check("rst_end_ready", 64'(highs), 64'd1);
        #1 rst = 1'b0;
        #1;
        check("rst_end", {result_o, ready_o}, 65'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b1;
        do_div("after_rst_end", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 32, 1);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
